pipelined_prefix_adder: RTL and testbench
=========================================

Name: pipelined_prefix_adder

Overview:
Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshakes on input and output.
- Pipeline: one register stage per prefix level, plus an input pre-processing stage.
- Flags: carry-out and signed overflow.
- Sits in the arithmetic datapath (adders group) as the general-width successor to the fixed 16-bit combinational prefix adder, for timing-closed use at high clock rates.

Parameters:
- WIDTH, 32, operand/sum width in bits; legal range 2..64, need not be a power of two.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not overridden.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low. Asserts asynchronously; release is synchronised externally.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. When sub=1, cout=1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits cleared; out_valid, sum, cout, ovf = 0; in_ready = 1 once released.
- Stage 0 (input):
  - on accept, register b_eff = sub ? ~b : b and c0 = sub ? 1 : cin;
  - register per-bit g=a&b_eff, p=a|b_eff, x=a^b_eff.
- Stages 1..LEVELS (prefix):
  - level k combines with distance 2^(k-1): G = Gi | (Pi & Gj), P = Pi & Pj;
  - c0 enters as the bit -1 generate;
  - indices below 0 pass through unchanged;
  - x and c0 are carried alongside.
- Output: sum = x ^ {carries[WIDTH-2:0], c0} is computed from the final prefix register and registered as the output stage.
- Latency: LEVELS+2 cycles from accept to out_valid with no stall; WIDTH=16 gives 6, WIDTH=32 gives 7.
- Throughput: one beat per cycle.
- Handshake:
  - global pipeline enable en = !out_valid | out_ready;
  - in_ready = en;
  - accept when in_valid & in_ready;
  - all stages advance together only when en=1.
  - While out_valid=1 and out_ready=0: sum/cout/ovf/out_valid hold stable, and no stage changes.
- Bubbles: an empty slot propagates as valid=0; data registers in invalid slots may hold stale data, but out_valid never asserts for a bubble.
- Simultaneous accept at input and drain at output in the same cycle is legal; there is no lost or duplicated beat.
- Reset mid-operation: all in-flight beats discarded; no output beat is produced for them.
- WIDTH not a power of two: the top prefix level only touches indices < WIDTH.

Optional Feature:
- Macro: PREFIX_ADDER_SAT_EN.
- Defined:
  - when ovf=1, sum is clamped to signed max (0111..1) if operand sign bits, after b_eff inversion, are both 0; otherwise to signed min (1000..0);
  - cout and ovf are still reported unclamped;
  - adds one mux level on the output stage; latency unchanged.
- Undefined: sum always wraps modulo 2^WIDTH.

Decomposition:
- Package adder_pkg:
  - clog2 helper;
  - typedef for the per-stage bundle {valid, g, p, x, c0};
  - localparam for the sub/add mode encoding.
- Sub-module prefix_level: one combinational prefix level for a given DISTANCE and WIDTH, instantiated LEVELS times via generate.
- Registers and the enable stay in the top block.

Test Plan:
1. WIDTH=16; a=16'hFFFF, b=16'h0001, cin=0, sub=0, out_ready=1 -> after 6 cycles: sum=16'h0000, cout=1, ovf=0.
2. WIDTH=16; a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1, cout=0; with PREFIX_ADDER_SAT_EN: sum=16'h7FFF.
3. WIDTH=16; a=16'h0003, b=16'h0005, sub=1 -> sum=16'hFFFE, cout=0 (borrow), ovf=0.
4. Back-to-back, 100 random beats, random out_ready toggling -> every beat matches a reference model in order; no drops or duplicates; outputs stable while stalled.
5. Reset pulse asserted 3 cycles after 4 beats are accepted -> outputs 0 immediately; no stale beat appears after release; next beat has correct latency.
6. WIDTH=13 (non-power-of-two), exhaustive edge set {0, 1, max, 0x1000, 0x0FFF} x cin {0,1} -> all sums/cout correct; latency 6.

Source files
------------

// File: rtl/adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared types, mode encoding and helpers for the pipelined
//               parallel-prefix adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Fixed at MAX_WIDTH so every stage shares one type; bits at or above the
  // instance WIDTH are held at zero and pass straight through.
  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] g;
    logic [MAX_WIDTH-1:0] p;
    logic [MAX_WIDTH-1:0] x;
    logic                 c0;
  } stage_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prefix_level.sv
// ============================================================================
// Module      : prefix_level
// Description : One combinational Kogge-Stone level combining each bit with
//               the bit DISTANCE positions below it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefix_level
  import adder_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DISTANCE = 1
) (
  input  stage_t stage_i,
  output stage_t stage_o
);

  always_comb begin
    stage_o = stage_i;
    for (int i = DISTANCE; i < WIDTH; i++) begin
      stage_o.g[i] = stage_i.g[i] | (stage_i.p[i] & stage_i.g[i-DISTANCE]);
      stage_o.p[i] = stage_i.p[i] & stage_i.p[i-DISTANCE];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_prefix_adder.sv
// ============================================================================
// Module      : pipelined_prefix_adder
// Description : Pipelined Kogge-Stone adder/subtractor with valid/ready
//               handshakes. Define PREFIX_ADDER_SAT_EN for saturating sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_prefix_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] b_eff;
  stage_t           stage_d;
  stage_t           stage_q [LEVELS+1];
  stage_t           level_o [LEVELS];
  stage_t           fin;

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_wrap;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign en       = !out_valid_q | out_ready;
  assign in_ready = en;

  always_comb begin
    b_eff            = (sub == MODE_SUB) ? ~b : b;
    stage_d          = '0;
    stage_d.valid    = in_valid;
    stage_d.c0       = (sub == MODE_SUB) ? 1'b1 : cin;
    stage_d.g[WIDTH-1:0] = a & b_eff;
    stage_d.p[WIDTH-1:0] = a | b_eff;
    stage_d.x[WIDTH-1:0] = a ^ b_eff;
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    prefix_level #(
      .WIDTH    (WIDTH),
      .DISTANCE (1 << k)
    ) u_level (
      .stage_i (stage_q[k]),
      .stage_o (level_o[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LEVELS; k++) stage_q[k] <= '0;
    end else if (en) begin
      stage_q[0] <= stage_d;
      for (int k = 1; k <= LEVELS; k++) stage_q[k] <= level_o[k-1];
    end
  end

  assign fin = stage_q[LEVELS];

  // The final level spans bit i down to bit 0, so c0 acting as the bit -1
  // generate folds in with a single G | P&c0 per bit.
  always_comb begin
    carry    = fin.g[WIDTH-1:0] | (fin.p[WIDTH-1:0] & {WIDTH{fin.c0}});
    sum_wrap = fin.x[WIDTH-1:0] ^ {carry[WIDTH-2:0], fin.c0};
    cout_d   = carry[WIDTH-1];
    ovf_d    = carry[WIDTH-1] ^ carry[WIDTH-2];
    sum_d    = sum_wrap;
`ifdef PREFIX_ADDER_SAT_EN
    // On overflow both operand signs agree, and the wrapped MSB is their
    // inverse: MSB=1 means two non-negative operands overflowed upward.
    if (ovf_d) begin
      sum_d = sum_wrap[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= fin.valid;
      if (fin.valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_prefix_adder.sv
// ============================================================================
// Module      : tb_pipelined_prefix_adder
// Description : Self-checking bench driving a 16-bit and a 13-bit instance
//               in lockstep with directed and model-checked beats.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_prefix_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] sum16;
  logic        in_ready13, out_valid13, cout13, ovf13;
  logic [12:0] sum13;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rnd_rdy  = 1'b0;
  bit lat_chk  = 1'b1;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s16;
    logic        c16, o16;
    logic [12:0] s13;
    logic        c13, o13;
    int          acc;
  } beat_t;

  beat_t stim[$];
  beat_t sb[$];

  bit          prev_stall = 1'b0;
  logic [15:0] hold_sum;
  logic        hold_cout, hold_ovf;

`ifdef PREFIX_ADDER_SAT_EN
  localparam logic [15:0] T2_SUM = 16'h7FFF;
  localparam logic [15:0] T4_SUM = 16'h8000;
  localparam logic [15:0] T5_SUM = 16'h8000;
`else
  localparam logic [15:0] T2_SUM = 16'h8000;
  localparam logic [15:0] T4_SUM = 16'h0000;
  localparam logic [15:0] T5_SUM = 16'h7FFF;
`endif

  pipelined_prefix_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid16),
    .out_ready(out_ready), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  pipelined_prefix_adder #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready13),
    .a(a[12:0]), .b(b[12:0]), .cin(cin), .sub(sub), .out_valid(out_valid13),
    .out_ready(out_ready), .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition at width w.
  function automatic void model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                input logic ci_in, input logic sb_in,
                                output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] m17, full;
    logic [15:0] mask, aa, be;
    logic        ci;
    m17  = (17'd1 << w) - 17'd1;
    mask = m17[15:0];
    aa   = ai & mask;
    be   = (sb_in ? ~bi : bi) & mask;
    ci   = sb_in | ci_in;
    full = {1'b0, aa} + {1'b0, be} + {16'd0, ci};
    s    = full[15:0] & mask;
    co   = full[w];
    ov   = (aa[w-1] == be[w-1]) && (s[w-1] != aa[w-1]);
`ifdef PREFIX_ADDER_SAT_EN
    if (ov) s = aa[w-1] ? (16'd1 << (w-1)) : (mask >> 1);
`endif
  endfunction

  task automatic push_dir(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic si,
                          input logic [15:0] s16, input logic c16, input logic o16);
    beat_t e;
    logic [15:0] s;
    e.a = ai; e.b = bi; e.cin = ci; e.sub = si;
    e.s16 = s16; e.c16 = c16; e.o16 = o16;
    model(13, ai, bi, ci, si, s, e.c13, e.o13);
    e.s13 = s[12:0];
    e.acc = 0;
    stim.push_back(e);
  endtask

  task automatic push_mod(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input logic si);
    logic [15:0] s;
    logic        c, o;
    model(16, ai, bi, ci, si, s, c, o);
    push_dir(ai, bi, ci, si, s, c, o);
  endtask

  task automatic step();
    beat_t e;
    @(negedge clk);
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stim.size() > 0) begin
      in_valid = 1'b1;
      a = stim[0].a; b = stim[0].b; cin = stim[0].cin; sub = stim[0].sub;
    end else begin
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
    end
    #1;
    if (prev_stall) begin
      check("hold_valid", 64'(out_valid16), 64'd1);
      check("hold_sum",   64'(sum16),       64'(hold_sum));
      check("hold_cout",  64'(cout16),      64'(hold_cout));
      check("hold_ovf",   64'(ovf16),       64'(hold_ovf));
    end
    if (out_valid16 && out_ready) begin
      if (sb.size() == 0) begin
        check("out_valid_no_beat", 64'(out_valid16), 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum16",  64'(sum16),  64'(e.s16));
        check("cout16", 64'(cout16), 64'(e.c16));
        check("ovf16",  64'(ovf16),  64'(e.o16));
        check("valid13", 64'(out_valid13), 64'd1);
        check("sum13",  64'(sum13),  64'(e.s13));
        check("cout13", 64'(cout13), 64'(e.c13));
        check("ovf13",  64'(ovf13),  64'(e.o13));
        if (lat_chk) check("latency", 64'(cyc - e.acc), 64'd6);
      end
    end
    prev_stall = out_valid16 && !out_ready;
    hold_sum   = sum16;
    hold_cout  = cout16;
    hold_ovf   = ovf16;
    if (in_valid && in_ready16) begin
      e = stim.pop_front();
      e.acc = cyc;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic run_until_empty();
    int guard;
    guard = 0;
    while ((stim.size() > 0 || sb.size() > 0) && guard < 3000) begin
      step();
      guard++;
    end
    if (guard >= 3000) check("drain_timeout", 64'(stim.size() + sb.size()), 64'd0);
  endtask

  logic [15:0] edge13 [5];

  initial begin
    edge13[0] = 16'h0000; edge13[1] = 16'h0001; edge13[2] = 16'h1FFF;
    edge13[3] = 16'h1000; edge13[4] = 16'h0FFF;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid16), 64'd0);
    check("rst_sum",       64'(sum16),       64'd0);
    check("rst_cout",      64'(cout16),      64'd0);
    check("rst_ovf",       64'(ovf16),       64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  64'(in_ready16),  64'd1);

    // Directed vectors with hand-computed results
    rnd_rdy = 1'b0; lat_chk = 1'b1;
    push_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    push_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, T2_SUM,   1'b0, 1'b1);
    push_dir(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    push_dir(16'h8000, 16'h8000, 1'b0, 1'b0, T4_SUM,   1'b1, 1'b1);
    push_dir(16'h8000, 16'h0001, 1'b0, 1'b1, T5_SUM,   1'b1, 1'b1);
    push_dir(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    push_dir(16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_until_empty();

    // Non-power-of-two edge set, both instances checked against the model
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int c = 0; c < 2; c++)
          push_mod(edge13[i], edge13[j], 1'(c), 1'b0);
    run_until_empty();

    // Back-to-back random beats with random downstream stalls
    rnd_rdy = 1'b1; lat_chk = 1'b0;
    for (int i = 0; i < 100; i++)
      push_mod(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_until_empty();

    // Reset while beats are in flight
    rnd_rdy = 1'b0; lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) push_mod(16'(i * 16'h1111), 16'h0101, 1'b0, 1'b0);
    while (stim.size() > 0) step();
    repeat (3) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid16), 64'd0);
    check("midrst_sum",       64'(sum16),       64'd0);
    check("midrst_valid13",   64'(out_valid13), 64'd0);
    sb.delete();
    stim.delete();
    in_valid   = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    push_dir(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_until_empty();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
